perceptron_cmd: RTL and testbench

PERCEPTRON_CMD -- requirements
Module: perceptron_cmd

---
 rtl/perceptron_cmd_pkg.sv | 33 +++
 rtl/perceptron_cmd_if.sv | 24 ++
 rtl/perceptron_lane.sv | 54 +++++
 rtl/perceptron_cmd.sv | 165 ++++++++++++++++
 tb/tb_perceptron_cmd.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_cmd_pkg.sv
// perceptron_cmd_pkg
//   Shared definitions for the perceptron command engine: opcode values,
//   the frame-decoder FSM state encoding, the per-lane operation select and
//   the default frame start byte.
package perceptron_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_PAYLOAD,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        LANE_HOLD,
        LANE_CLEAR,
        LANE_MUL,
        LANE_MAC,
        LANE_ADD
    } lane_op_t;

    localparam logic [7:0] OP_LOAD_A = 8'd0;
    localparam logic [7:0] OP_LOAD_B = 8'd1;
    localparam logic [7:0] OP_READ   = 8'd2;
    localparam logic [7:0] OP_CLEAR  = 8'd3;
    localparam logic [7:0] OP_MUL    = 8'd5;
    localparam logic [7:0] OP_MAC    = 8'd6;
    localparam logic [7:0] OP_DOT    = 8'd7;

    localparam logic [7:0] HEADER_DEFAULT = 8'd100;

endpackage

// File: rtl/perceptron_cmd_if.sv
// perceptron_cmd_if
//   Byte-stream command interface of the perceptron engine.
//   in_valid/in_data : received byte strobe, no backpressure
//   out_valid/out_data/out_ready : response byte handshake
//   err : sticky error flag
//   master = command source / response sink, slave = the engine.
interface perceptron_cmd_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       err;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, err
    );
endinterface

// File: rtl/perceptron_lane.sv
// perceptron_lane
//   One multiply lane: unsigned DW x DW product and a saturating ACC_W
//   accumulator.
//   clk, rst   : clock, asynchronous active-high reset
//   a, b       : operands
//   op         : accumulator operation for this cycle
//   ext_add    : external addend used by LANE_ADD (dot-product sum)
//   prod       : combinational a*b
//   acc        : accumulator
//   ovf        : the MAC/ADD performed this cycle saturates
module perceptron_lane
    import perceptron_cmd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int EXT_W = 2*DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    input  lane_op_t          op,
    input  logic [EXT_W-1:0]  ext_add,
    output logic [2*DW-1:0]   prod,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    // One spare bit above the widest operand catches any carry out.
    localparam int SW = ((ACC_W > EXT_W) ? ACC_W : EXT_W) + 1;

    logic [EXT_W-1:0] addend;
    logic [SW-1:0]    sum_w;

    assign prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign addend = (op == LANE_ADD) ? ext_add : EXT_W'(prod);
    assign sum_w  = SW'(acc) + SW'(addend);
    assign ovf    = ((op == LANE_MAC) || (op == LANE_ADD)) &&
                    (sum_w[SW-1:ACC_W] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            case (op)
                LANE_CLEAR:        acc <= '0;
                LANE_MUL:          acc <= ACC_W'(prod);
                LANE_MAC, LANE_ADD: acc <= ovf ? '1 : sum_w[ACC_W-1:0];
                default:           acc <= acc;
            endcase
        end
    end

endmodule

// File: rtl/perceptron_cmd.sv
// perceptron_cmd
//   Framed byte-command perceptron engine. Frames are HEADER, opcode and
//   LANES*DW/8 payload bytes (LSB first, lane 0 first). Supports loading
//   the A/B operand banks, MUL/MAC/DOT into per-lane accumulators, CLEAR,
//   and READ which streams all accumulators back (lane 0 first, LSB first).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : perceptron_cmd_if slave (byte in, response handshake, err)
module perceptron_cmd
    import perceptron_cmd_pkg::*;
#(
    parameter int         LANES  = 4,
    parameter int         DW     = 8,
    parameter int         ACC_W  = 24,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    perceptron_cmd_if.slave   bus
);

    localparam int P     = LANES*DW/8;
    localparam int R     = LANES*ACC_W/8;
    localparam int CNT_W = $clog2(R) + 1;
    localparam int EXT_W = 2*DW + $clog2(LANES);

    state_t                   state;
    logic [7:0]               opcode;
    logic [CNT_W-1:0]         cnt;
    logic [LANES*DW-1:0]      pay;
    logic [LANES*DW-1:0]      a_reg;
    logic [LANES*DW-1:0]      b_reg;
    logic [LANES*ACC_W-1:0]   resp_buf;
    logic                     out_valid_q;
    logic [7:0]               out_data_q;
    logic                     err_q;

    logic [LANES*ACC_W-1:0]   acc_flat;
    logic [LANES*2*DW-1:0]    prod_flat;
    logic [LANES-1:0]         ovf_vec;
    logic [EXT_W-1:0]         dot_sum;
    lane_op_t                 lane_op [LANES];

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;

    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < LANES; i++)
            dot_sum = dot_sum + EXT_W'(prod_flat[i*2*DW +: 2*DW]);
    end

    // Lane operations are only issued in the single EXEC cycle.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_op[i] = LANE_HOLD;
            if (state == ST_EXEC) begin
                case (opcode)
                    OP_CLEAR: lane_op[i] = LANE_CLEAR;
                    OP_MUL:   lane_op[i] = LANE_MUL;
                    OP_MAC:   lane_op[i] = LANE_MAC;
                    OP_DOT:   lane_op[i] = (i == 0) ? LANE_ADD : LANE_HOLD;
                    default:  lane_op[i] = LANE_HOLD;
                endcase
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        perceptron_lane #(
            .DW    (DW),
            .ACC_W (ACC_W),
            .EXT_W (EXT_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .a       (a_reg[g*DW +: DW]),
            .b       (b_reg[g*DW +: DW]),
            .op      (lane_op[g]),
            .ext_add (dot_sum),
            .prod    (prod_flat[g*2*DW +: 2*DW]),
            .acc     (acc_flat[g*ACC_W +: ACC_W]),
            .ovf     (ovf_vec[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            opcode      <= '0;
            cnt         <= '0;
            pay         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            resp_buf    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && (bus.in_data == HEADER))
                        state <= ST_OPC;
                end
                ST_OPC: begin
                    if (bus.in_valid) begin
                        opcode <= bus.in_data;
                        cnt    <= '0;
                        state  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (bus.in_valid) begin
                        pay[int'(cnt)*8 +: 8] <= bus.in_data;
                        if (cnt == CNT_W'(P-1)) begin
                            cnt   <= '0;
                            state <= ST_EXEC;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    case (opcode)
                        OP_LOAD_A: a_reg <= pay;
                        OP_LOAD_B: b_reg <= pay;
                        OP_READ: begin
                            // Snapshot now; the first byte goes out directly.
                            resp_buf    <= acc_flat;
                            out_data_q  <= acc_flat[7:0];
                            out_valid_q <= 1'b1;
                            cnt         <= '0;
                            state       <= ST_RESP;
                        end
                        OP_CLEAR: err_q <= 1'b0;
                        OP_MUL, OP_MAC, OP_DOT: begin
                            if (|ovf_vec)
                                err_q <= 1'b1;
                        end
                        default: err_q <= 1'b1;
                    endcase
                end
                ST_RESP: begin
                    if (bus.in_valid)
                        err_q <= 1'b1;
                    if (bus.out_ready) begin
                        if (cnt == CNT_W'(R-1)) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            cnt         <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            resp_buf   <= resp_buf >> 8;
                            out_data_q <= resp_buf[15:8];
                            cnt        <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_cmd.sv
// tb_perceptron_cmd
//   Drives one byte stream into two engines (default ACC_W=24 and ACC_W=16)
//   and compares their responses and err flags against a behavioural model.
module tb_perceptron_cmd;
    import perceptron_cmd_pkg::*;

    localparam int LANES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    perceptron_cmd_if bus24();
    perceptron_cmd_if bus16();

    assign bus24.in_valid  = in_valid;
    assign bus24.in_data   = in_data;
    assign bus24.out_ready = out_ready;
    assign bus16.in_valid  = in_valid;
    assign bus16.in_data   = in_data;
    assign bus16.out_ready = out_ready;

    perceptron_cmd dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24)
    );

    perceptron_cmd #(.ACC_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] ma [LANES];
    logic [63:0] mb [LANES];
    logic [63:0] acc24 [LANES];
    logic [63:0] acc16 [LANES];
    bit          err24, err16;
    logic [7:0]  q24 [$];
    logic [7:0]  q16 [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w, output bit o);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        o  = (a + b) > mx;
        return o ? mx : (a + b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            ma[i] = 0; mb[i] = 0; acc24[i] = 0; acc16[i] = 0;
        end
        err24 = 0; err16 = 0;
        q24.delete(); q16.delete();
    endtask

    task automatic model_exec(input logic [7:0] op, input logic [7:0] pl [LANES]);
        bit o;
        logic [63:0] s;
        case (op)
            8'd0: for (int i = 0; i < LANES; i++) ma[i] = 64'(pl[i]);
            8'd1: for (int i = 0; i < LANES; i++) mb[i] = 64'(pl[i]);
            8'd2: for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < 3; j++) q24.push_back(8'((acc24[i] >> (8*j)) & 64'hff));
                for (int j = 0; j < 2; j++) q16.push_back(8'((acc16[i] >> (8*j)) & 64'hff));
            end
            8'd3: begin
                for (int i = 0; i < LANES; i++) begin acc24[i] = 0; acc16[i] = 0; end
                err24 = 0; err16 = 0;
            end
            8'd5: for (int i = 0; i < LANES; i++) begin
                acc24[i] = ma[i] * mb[i]; acc16[i] = ma[i] * mb[i];
            end
            8'd6: for (int i = 0; i < LANES; i++) begin
                acc24[i] = sat_add(acc24[i], ma[i] * mb[i], 24, o); if (o) err24 = 1;
                acc16[i] = sat_add(acc16[i], ma[i] * mb[i], 16, o); if (o) err16 = 1;
            end
            8'd7: begin
                s = 0;
                for (int i = 0; i < LANES; i++) s += ma[i] * mb[i];
                acc24[0] = sat_add(acc24[0], s, 24, o); if (o) err24 = 1;
                acc16[0] = sat_add(acc16[0], s, 16, o); if (o) err16 = 1;
            end
            default: begin err24 = 1; err16 = 1; end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3);
        logic [7:0] pl [LANES];
        pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3;
        send_byte(HEADER_DEFAULT);
        send_byte(op);
        for (int i = 0; i < LANES; i++) send_byte(pl[i]);
        model_exec(op, pl);
        @(posedge clk); #1;   // EXEC cycle
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q24.size() != 0 || q16.size() != 0 || bus24.out_valid || bus16.out_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain_done"}, 64'(n < 400), 64'd1);
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_err24"}, 64'(bus24.err), 64'(err24));
        chk({tag, "_err16"}, 64'(bus16.err), 64'(err16));
    endtask

    // Response scoreboard: every byte shown must match the queue head;
    // the head is only retired on acceptance, so a stall re-checks it.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus24.out_valid) begin
                chk("resp24_pending", 64'(q24.size() > 0), 64'd1);
                if (q24.size() > 0) begin
                    chk("resp24_byte", 64'(bus24.out_data), 64'(q24[0]));
                    if (out_ready) void'(q24.pop_front());
                end
            end
            if (bus16.out_valid) begin
                chk("resp16_pending", 64'(q16.size() > 0), 64'd1);
                if (q16.size() > 0) begin
                    chk("resp16_byte", 64'(bus16.out_data), 64'(q16[0]));
                    if (out_ready) void'(q16.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        model_reset();
        #22 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_valid24", 64'(bus24.out_valid), 64'd0);
        chk("rst_data24",  64'(bus24.out_data),  64'd0);
        chk("rst_valid16", 64'(bus16.out_valid), 64'd0);
        chk("rst_data16",  64'(bus16.out_data),  64'd0);
        chk_err("rst");

        // Stray bytes before a frame are ignored.
        send_byte(8'd7);
        send_byte(8'd55);
        send_frame(OP_LOAD_A, 1, 2, 3, 4);
        send_frame(OP_LOAD_B, 10, 20, 30, 40);
        send_frame(OP_MUL, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("mul");
        chk_err("mul");

        send_frame(OP_MAC, 0, 0, 0, 0);
        send_frame(OP_MAC, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("mac2");

        send_frame(OP_CLEAR, 0, 0, 0, 0);
        send_frame(OP_DOT, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("dot");
        chk_err("dot");

        // Unknown opcode: err set, nothing else changes.
        send_frame(8'd9, 11, 12, 13, 14);
        chk_err("unk");
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("unk_acc");
        send_frame(OP_MUL, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("unk_ab");
        send_frame(OP_CLEAR, 0, 0, 0, 0);
        chk_err("clear");

        // HEADER value inside the payload is plain data.
        send_frame(OP_LOAD_A, 100, 100, 3, 100);
        send_frame(OP_MUL, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("hdr_data");

        // Random MAC rounds.
        for (int k = 0; k < 3; k++) begin
            send_frame(OP_LOAD_A, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            send_frame(OP_LOAD_B, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            send_frame(OP_MAC, 0, 0, 0, 0);
            send_frame(OP_READ, 0, 0, 0, 0);
            drain("rand");
            chk_err("rand");
        end

        // Stalled response: first byte must hold for 50 cycles.
        out_ready = 1'b0;
        send_frame(OP_READ, 0, 0, 0, 0);
        repeat (50) begin @(posedge clk); #1; end
        chk("stall_valid24", 64'(bus24.out_valid), 64'd1);
        chk("stall_valid16", 64'(bus16.out_valid), 64'd1);
        out_ready = 1'b1;
        drain("stall");

        // Reset in the middle of a payload.
        send_byte(HEADER_DEFAULT);
        send_byte(OP_LOAD_A);
        send_byte(8'd9);
        send_byte(8'd9);
        rst = 1'b1;
        model_reset();
        #3;
        chk("arst_valid24", 64'(bus24.out_valid), 64'd0);
        chk("arst_data24",  64'(bus24.out_data),  64'd0);
        chk("arst_valid16", 64'(bus16.out_valid), 64'd0);
        chk("arst_data16",  64'(bus16.out_data),  64'd0);
        chk_err("arst");
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("post_rst_acc");
        send_frame(OP_MUL, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("post_rst_ab");
        send_frame(OP_LOAD_A, 5, 6, 7, 8);
        send_frame(OP_LOAD_B, 2, 3, 4, 5);
        send_frame(OP_MUL, 0, 0, 0, 0);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("post_rst_mul");
        chk_err("post_rst");

        // Saturation.
        send_frame(OP_CLEAR, 0, 0, 0, 0);
        send_frame(OP_LOAD_A, 255, 255, 255, 255);
        send_frame(OP_LOAD_B, 255, 255, 255, 255);
        repeat (300) send_frame(OP_MAC, 0, 0, 0, 0);
        chk_err("sat");
        chk("sat_model16", acc16[0], 64'd65535);
        send_frame(OP_READ, 0, 0, 0, 0);
        drain("sat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
